// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types for the ALU input sequencer: default operand
//                width, ALU opcode encoding and sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_NOT = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ST_LOAD_A  = 3'd0,
        ST_LOAD_B  = 3'd1,
        ST_LOAD_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SHOW    = 3'd4
    } state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_input_sequencer_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : 2-FF synchronizer, stable-level debouncer and rising-edge
//                press pulse for one raw push-button.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    // Counter only needs to reach DEB_CYCLES-1: the level flips on the cycle
    // the DEB_CYCLES-th consecutive differing sample is seen.
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    // Synchronize, count consecutive samples that differ from the accepted
    // level, and emit a single pulse when the accepted level rises.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_press <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/alu_input_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_input_sequencer
//  Description : Button-driven sequencer that loads A, B and an opcode from
//                slide switches, executes one ALU operation and shows the
//                registered result and flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_input_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH      = ALU_WIDTH,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_next,
    input  logic             btn_clr,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic [2:0]       step,
    output logic             done
);

    localparam int c_MSB = WIDTH - 1;

    logic w_next;
    logic w_clr;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_next),
        .o_press (w_next)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_clr),
        .o_press (w_clr)
    );

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    opcode_e          r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic             r_ovf;
    logic             r_done;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_LOAD_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clear overrides a simultaneous advance.
    always_comb begin
        w_state_nxt = r_state;
        if (w_clr) begin
            w_state_nxt = ST_LOAD_A;
        end else begin
            case (r_state)
                ST_LOAD_A:  if (w_next) w_state_nxt = ST_LOAD_B;
                ST_LOAD_B:  if (w_next) w_state_nxt = ST_LOAD_OP;
                ST_LOAD_OP: if (w_next) w_state_nxt = ST_EXEC;
                ST_EXEC:    w_state_nxt = ST_SHOW;
                ST_SHOW:    if (w_next) w_state_nxt = ST_LOAD_A;
                default:    w_state_nxt = ST_LOAD_A;
            endcase
        end
    end

    // ALU datapath evaluated at WIDTH+1 bits so carry/borrow fall out directly.
    always_comb begin
        w_sum   = {1'b0, r_a} + {1'b0, r_b};
        w_diff  = {1'b0, r_a} - {1'b0, r_b};
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (r_a[c_MSB] == r_b[c_MSB]) && (w_sum[c_MSB] != r_a[c_MSB]);
            end
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = ~w_diff[WIDTH];
                w_ovf   = (r_a[c_MSB] != r_b[c_MSB]) && (w_diff[c_MSB] != r_a[c_MSB]);
            end
            OP_AND: w_res = r_a & r_b;
            OP_OR:  w_res = r_a | r_b;
            OP_XOR: w_res = r_a ^ r_b;
            OP_SHL: begin
                w_res   = {r_a[WIDTH-2:0], 1'b0};
                w_carry = r_a[c_MSB];
            end
            OP_SHR: begin
                w_res   = {1'b0, r_a[WIDTH-1:1]};
                w_carry = r_a[0];
            end
            OP_NOT: w_res = ~r_a;
            default: w_res = '0;
        endcase
    end

    // Operand capture, result/flag register at the end of EXEC, done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_ADD;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_clr) begin
                r_a      <= '0;
                r_b      <= '0;
                r_op     <= OP_ADD;
                r_result <= '0;
                r_zero   <= 1'b0;
                r_carry  <= 1'b0;
                r_ovf    <= 1'b0;
            end else begin
                case (r_state)
                    ST_LOAD_A:  if (w_next) r_a <= sw;
                    ST_LOAD_B:  if (w_next) r_b <= sw;
                    ST_LOAD_OP: if (w_next) r_op <= opcode_e'(sw[2:0]);
                    ST_EXEC: begin
                        r_result <= w_res;
                        r_zero   <= (w_res == '0);
                        r_carry  <= w_carry;
                        r_ovf    <= w_ovf;
                        r_done   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign result   = r_result;
    assign zero     = r_zero;
    assign carry    = r_carry;
    assign overflow = r_ovf;
    assign step     = r_state;
    assign done     = r_done;

endmodule : alu_input_sequencer
`default_nettype wire
